// File: rtl/fetch_pkg.sv
// ---- fetch_pkg: fetch-stage state encoding, reset PC default, shared MIPS opcodes
// ---- rev 1.0
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [31:0] C_DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] C_OP_SPECIAL = 6'b000000;
  localparam logic [5:0] C_OP_J       = 6'b000010;
  localparam logic [5:0] C_OP_JAL     = 6'b000011;
  localparam logic [5:0] C_OP_BEQ     = 6'b000100;
  localparam logic [5:0] C_FUNCT_JR   = 6'b001000;

  // Branch displacement: sign-extended word offset scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_next_pc_logic.sv
// ---- next_pc_logic: next-PC select, priority jr > jump > branch > sequential
// ---- rev 1.0
`default_nettype none

module next_pc_logic
  import fetch_pkg::*;
(
  input  logic [31:0] i_pc_plus4,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_jr_target,
  input  logic        i_branch_taken,
  input  logic        i_jump,
  input  logic        i_jr,
  output logic [31:0] o_next_pc
);

  // Opcode bits are decoded upstream; only the immediate fields matter here.
  logic w_unused_opcode;
  assign w_unused_opcode = ^i_instr[31:26];

  always_comb begin
    o_next_pc = i_pc_plus4;
    if (i_jr) begin
      o_next_pc = i_jr_target;
    end else if (i_jump) begin
      o_next_pc = {i_pc_plus4[31:28], i_instr[25:0], 2'b00};
    end else if (i_branch_taken) begin
      o_next_pc = i_pc_plus4 + branch_offset(i_instr[15:0]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ---- fetch_unit: MIPS fetch stage (PC, imem req/ack, decode valid/ready, next PC)
// ---- Option FETCH_ALIGN_CHECK_EN: sticky fault on misaligned next PC. rev 1.0
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = C_DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  input  logic        i_branch_taken,
  input  logic        i_jump,
  input  logic        i_jr,
  input  logic [31:0] i_jr_target,
  output logic [31:0] o_fetch_count,
  output logic        o_fault
);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_count;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;
  logic [31:0] w_pc_load;
  logic        w_accept;
  logic        w_ack;
  logic        w_misaligned;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_accept   = (r_state == VALID) && i_instr_ready;
  assign w_ack      = (r_state == FETCH) && i_imem_ack;

  next_pc_logic u_next_pc (
    .i_pc_plus4    (w_pc_plus4),
    .i_instr       (r_instr),
    .i_jr_target   (i_jr_target),
    .i_branch_taken(i_branch_taken),
    .i_jump        (i_jump),
    .i_jr          (i_jr),
    .o_next_pc     (w_next_pc)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_fault;

  assign w_misaligned = |w_next_pc[1:0];
  assign w_pc_load    = w_next_pc;

  // The bad address is still loaded so it is visible on o_pc for debug.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault <= 1'b0;
    end else if (w_accept && w_misaligned) begin
      r_fault <= 1'b1;
    end
  end

  assign o_fault = r_fault;
`else
  logic [1:0] w_unused_low;

  assign w_unused_low = w_next_pc[1:0];
  assign w_misaligned = 1'b0;
  assign w_pc_load    = {w_next_pc[31:2], 2'b00};
  assign o_fault      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FETCH: begin
        if (i_imem_ack) begin
          w_next_state = VALID;
        end
      end
      VALID: begin
        if (i_instr_ready) begin
          w_next_state = w_misaligned ? FAULT : FETCH;
        end
      end
      default: w_next_state = r_state;
    endcase
  end

  // Request is gated by rst so nothing is issued during reset.
  always_comb begin
    o_imem_req    = 1'b0;
    o_instr_valid = 1'b0;
    case (r_state)
      FETCH:   o_imem_req    = !rst;
      VALID:   o_instr_valid = 1'b1;
      default: begin
        o_imem_req    = 1'b0;
        o_instr_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_instr <= 32'h0;
      r_count <= 32'h0;
    end else begin
      if (w_ack) begin
        r_instr <= i_imem_rdata;
      end
      if (w_accept) begin
        r_pc    <= w_pc_load;
        r_count <= r_count + 32'd1;
      end
    end
  end

  assign o_imem_addr   = r_pc;
  assign o_pc          = r_pc;
  assign o_pc_plus4    = w_pc_plus4;
  assign o_instr       = r_instr;
  assign o_fetch_count = r_count;

endmodule

`default_nettype wire
